// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary in, packed BCD out.
// One bit is shifted per clock; digits_bcd only changes on the completion
// edge, so a downstream display never sees an intermediate value. Inputs
// above 10^NDIG-1 produce all nines and raise ovf.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   bin,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [4*NDIG-1:0]  digits_bcd,
    output logic               ovf
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX = pow10(NDIG) - 1;

    // Add 3 to every nibble that is 5 or more, so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Saturated display value: every digit 9.
    function automatic logic [BCD_W-1:0] all_nines();
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'h9;
        end
        return r;
    endfunction

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     accept;
    logic                     finish;
    logic [BCD_W-1:0]         bcd_q;
    logic [BIN_W-1:0]         bin_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     over_q;
    logic [BCD_W+BIN_W-1:0]   shifted;

    // One double-dabble step: adjust pre-shift nibbles, then shift {bcd, bin}
    // left by one. Carries out of the top nibble fall off the end.
    always_comb begin
        shifted = {add3(bcd_q), bin_q} << 1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept a request in IDLE, leave SHIFT after the last bit.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // Shift register, bit counter and overflow capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            over_q <= 1'b0;
        end else if (accept) begin
            bcd_q  <= '0;
            bin_q  <= bin;
            cnt_q  <= '0;
            over_q <= (64'(bin) > MAX);
        end else if (state == SHIFT) begin
            bcd_q  <= shifted[BCD_W+BIN_W-1:BIN_W];
            bin_q  <= shifted[BIN_W-1:0];
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers: updated only on the completion edge, done pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            digits_bcd <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                digits_bcd <= over_q ? all_nines() : shifted[BCD_W+BIN_W-1:BIN_W];
                ovf        <= over_q;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: single conversions, overflow, ignored
// start while busy, mid-conversion reset and back-to-back conversions.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic [13:0] bin;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] digits_bcd;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    bin_to_bcd_seq #(.BIN_W(14), .NDIG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bin        (bin),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .digits_bcd (digits_bcd),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion started by a one-cycle start pulse. If inj > 0, a second
    // start with bin=9999 is raised in the inj-th busy cycle and must be ignored.
    task automatic run_conv(input logic [13:0] b, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input int inj, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (inj > 0 && i == inj) begin
                bin   = 14'd9999;
                start = 1'b1;
            end
            if (inj > 0 && i == inj + 1) begin
                start = 1'b0;
                bin   = b;
            end
        end
        check({tag, "_latency"}, lat, 32'd14);
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_bcd"}, {16'd0, digits_bcd}, {16'd0, exp_bcd});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_bcd_hold"}, {16'd0, digits_bcd}, {16'd0, exp_bcd});
    endtask

    initial begin
        logic [13:0] seq_bin [3];
        logic [15:0] seq_bcd [3];
        int   k;
        int   last_cyc;
        logic stable;
        logic spurious;

        rst   = 1'b1;
        bin   = '0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {16'd0, digits_bcd}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv(14'd1234,  16'h1234, 1'b0, 0, "c1234");
        run_conv(14'd0,     16'h0000, 1'b0, 0, "c0");
        run_conv(14'd9999,  16'h9999, 1'b0, 0, "c9999");
        run_conv(14'd5678,  16'h5678, 1'b0, 0, "c5678");
        run_conv(14'd12000, 16'h9999, 1'b1, 0, "c12000");
        run_conv(14'd42,    16'h0042, 1'b0, 0, "c42");
        run_conv(14'd10000, 16'h9999, 1'b1, 0, "c10000");
        run_conv(14'd1234,  16'h1234, 1'b0, 5, "ignore");

        // Reset in the middle of a conversion of 5678.
        @(negedge clk);
        bin   = 14'd5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_bcd", {16'd0, digits_bcd}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) spurious = 1'b1;
        end
        check("midrst_quiet", {31'd0, spurious}, 32'd0);
        run_conv(14'd5678, 16'h5678, 1'b0, 0, "after_rst");

        // Start held high: bin steps on each done.
        seq_bin[0] = 14'd1234; seq_bcd[0] = 16'h1234;
        seq_bin[1] = 14'd5678; seq_bcd[1] = 16'h5678;
        seq_bin[2] = 14'd9999; seq_bcd[2] = 16'h9999;
        @(negedge clk);
        bin      = seq_bin[0];
        start    = 1'b1;
        k        = 0;
        last_cyc = 0;
        stable   = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check($sformatf("seq%0d_bcd", k), {16'd0, digits_bcd}, {16'd0, seq_bcd[k]});
                if (k == 0) check("seq0_latency", cyc, 32'd15);
                else check($sformatf("seq%0d_period", k), cyc - last_cyc, 32'd15);
                last_cyc = cyc;
                k++;
                if (k == 3) break;
                bin = seq_bin[k];
            end else if (k > 0 && digits_bcd !== seq_bcd[k-1]) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        check("seq_count", k, 32'd3);
        check("seq_stable", {31'd0, stable}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD.
- Sits directly upstream of the time-multiplexed 7-segment driver; its digits_bcd output feeds that driver's digits_bcd input.
- digits_bcd holds the last completed result, so the display never shows partial conversions.
- Values above the displayable range saturate to all nines and raise an overflow flag.

Parameters:
- BIN_W, 14, width of binary input; also the number of shift cycles per conversion.
- NDIG, 4, number of BCD digits; output width is 4*NDIG; MAX = 10^NDIG - 1 (9999 at defaults).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bin  input  BIN_W  unsigned binary value; sampled only on the accepting edge.
- start  input  1  request conversion; honoured only in IDLE.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when digits_bcd/ovf update.
- digits_bcd  output  4*NDIG  packed BCD result, digit 0 in [3:0], most significant digit in the top nibble.
- ovf  output  1  last completed input exceeded MAX.

Behaviour:
- Reset (async, any time including mid-conversion): state=IDLE; busy=0, done=0, digits_bcd=0, ovf=0; shift register and counter cleared. Conversion restarts only on a new start after rst deasserts.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - latch bin into the binary part of the shift register; clear the BCD part; counter=0.
  - set busy=1 and move to SHIFT.
  - set over_q = (bin > MAX).
- SHIFT, each edge:
  - add 3 to every BCD nibble whose value is >= 5.
  - shift the whole {bcd, bin} register left by 1.
  - counter increments.
- SHIFT, edge where counter = BIN_W-1 (the BIN_W-th shift, edge k+BIN_W):
  - digits_bcd <= over_q ? all nibbles 4'h9 : converted BCD.
  - ovf <= over_q.
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle following edge k+BIN_W, i.e. BIN_W cycles after the accepting edge (14 at default).
- busy is high from after edge k through edge k+BIN_W; busy and done are never both high.
- start while busy is ignored: no restart, no queuing, and bin is not resampled.
- start high in the cycle done is high (state IDLE) is accepted, giving back-to-back conversions with no dead cycle.
- start held high continuously gives a new conversion every BIN_W+1 cycles.
- digits_bcd and ovf change only on the completion edge or reset and hold their value otherwise; intermediate BCD values are never visible on digits_bcd.
- BCD internal width is 4*NDIG; carries beyond the top nibble are discarded. This only happens when over_q=1, in which case the result is replaced by all nines.
- The add-3 and shift happen in the same cycle, with the add applied to pre-shift nibble values.
- Output nibbles are always in the range 0..9.

Test Plan:
- Reset, then bin=1234, 1-cycle start -> busy high for 14 cycles; done pulse 14 cycles after the start edge; digits_bcd=16'h1234, ovf=0.
- bin=0 -> digits_bcd=16'h0000, ovf=0. bin=9999 -> digits_bcd=16'h9999, ovf=0. bin=5678 -> 16'h5678.
- bin=12000 (>MAX) -> digits_bcd=16'h9999, ovf=1. Then bin=42 -> digits_bcd=16'h0042, ovf cleared to 0.
- Start bin=1234; at cycle 5 of busy pulse start with bin=9999 -> ignored; result 16'h1234; exactly one done pulse.
- Assert rst at cycle 7 of a conversion of 5678 -> busy, done, digits_bcd, ovf all 0 immediately (async); no done pulse afterward. After release, bin=5678 start -> 16'h5678.
- start held high with bin stepping 1234 -> 5678 -> 9999, changing on each done -> done pulses every 15 cycles; results 16'h1234, 16'h5678, 16'h9999 in order; digits_bcd stable between updates.
